score_bcd_encoder: RTL and testbench
====================================

# score_bcd_encoder

Sequential binary-to-BCD converter for the game score and other on-screen or 7-segment counters. It takes a binary value from game logic and produces packed BCD digits that feed the per-digit hex decoders. It also produces a leading-zero blanking mask and an overflow flag. Conversion is iterative (shift-add-3, one bit per clock), so a 16-bit score costs one small adder per digit rather than a divider.

## Interface
Parameters:
- WIDTH, 16, width of the binary input in bits; legal range 1–32.
- DIGITS, 5, number of BCD digits produced; legal range 1–8.

Ports:
- clk  in  1  system clock (50 MHz).
- resetn  in  1  reset; synchronous, active-low.
- start  in  1  conversion request; sampled only while busy=0.
- bin  in  WIDTH  binary value; captured on the accepting edge only.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bcd, digit_en and overflow are updated on the same edge.
- bcd  out  4*DIGITS  packed result; digit 0 (ones) is in bits [3:0].
- digit_en  out  DIGITS  leading-zero mask; bit i=1 means digit i should be displayed.
- overflow  out  1  the last result did not fit in DIGITS digits.

## Operation
- FSM with two states, IDLE and CONV. Reset state is IDLE.
- IDLE, start=1: on that edge:
  - load bin into the shift register;
  - clear the BCD scratch (4*DIGITS bits) and the overflow scratch;
  - set the bit counter to WIDTH;
  - set busy to 1 and go to CONV.
- IDLE, start=0: hold all registers.
- CONV, each edge:
  - in the scratch, add 3 to every digit whose value is ≥5;
  - shift {scratch, shift register} left by one bit;
  - OR the bit shifted out of the top of the scratch into the overflow scratch;
  - decrement the counter.
- CONV, edge where the counter goes 1→0 (the WIDTH-th shift):
  - write the post-shift scratch to bcd;
  - write the overflow scratch, including this shift's carry, to overflow;
  - write digit_en computed from the new digits;
  - set done=1 and busy=0, and return to IDLE.
- done is forced to 0 on every other edge.
- digit_en rules:
  - bit 0 is always 1;
  - bit i (i≥1) is 1 if any digit j≥i of the new result is nonzero.
- While busy=1:
  - start and bin are ignored; the request is dropped, not queued;
  - bcd, digit_en and overflow hold the previous result and stay stable for the display.
- Arithmetic:
  - the add-3 step is applied per digit before the shift, on 4-bit values; no digit exceeds 9 after the shift;
  - bin is treated as unsigned.
- Overflow:
  - the sticky OR is set when bin > 10^DIGITS − 1;
  - when set, bcd holds the low DIGITS decimal digits of bin, i.e. bin mod 10^DIGITS.

## Timing
- Reset values: busy=0, done=0, bcd=0, digit_en=1 (only bit 0 set), overflow=0, state IDLE, counter 0.
- Latency: let the accepting edge be E0.
  - Shifts occur on E1..E_WIDTH.
  - busy is high from after E0 until E_WIDTH.
  - done is high for exactly the cycle after E_WIDTH.
  - Accept-to-done is WIDTH clock cycles; at 16 bits this is well under one 60 FPS frame.
- Back-to-back: busy=0 during the done cycle, so a start held high then is accepted on the next edge. Sustained throughput is one conversion per WIDTH+1 cycles.
- Reset mid-conversion: resetn=0 on any edge aborts immediately. All outputs take their reset values; no done pulse is produced.
- start held high continuously: a new conversion begins every WIDTH+1 cycles, each capturing bin as it is on its own accepting edge.

## Test plan
- Reset, then idle 5 cycles -> busy=0, done=0, bcd=0x00000, digit_en=5'b00001, overflow=0 throughout.
- bin=0, 1-cycle start -> done pulses exactly 16 cycles after acceptance; bcd=0x00000, digit_en=5'b00001, overflow=0.
- bin=65535 -> bcd=0x65535, digit_en=5'b11111, overflow=0. bin=1234 -> bcd=0x01234, digit_en=5'b01111.
- Start with bin=42; at cycle 5 of the conversion pulse start with bin=999 -> single done pulse, bcd=0x00042. The second request is ignored and bcd stays stable while busy.
- start held high with bin=7, then bin=8 during the first conversion -> done pulses 17 cycles apart; the results are 0x00007, then 0x00008.
- Assert resetn=0 at cycle 8 of a conversion of bin=500 -> no done pulse, and all outputs take their reset values. WIDTH=10, DIGITS=3, bin=1000 -> bcd=0x000, overflow=1, digit_en=3'b001.

Source files
------------

// File: rtl/score_bcd_encoder.sv
// Iterative binary-to-BCD converter (shift-add-3, one bit per clock) with
// leading-zero blanking mask and overflow flag for the score display.
module score_bcd_encoder #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  overflow
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic {StIdle, StConv} state_e;

   state_e            r_state, w_state_nxt;
   logic [WIDTH-1:0]  r_shift, w_shift_nxt;
   logic [BW-1:0]     r_scratch, w_scratch_nxt;
   logic              r_ovf, w_ovf_nxt;
   logic [CW-1:0]     r_cnt, w_cnt_nxt;
   logic              r_done, w_done_nxt;
   logic [BW-1:0]     r_bcd, w_bcd_nxt;
   logic [DIGITS-1:0] r_en, w_en_nxt;
   logic              r_overflow, w_overflow_nxt;

   logic [BW-1:0]     w_adj;
   logic [BW-1:0]     w_scr_shift;
   logic              w_carry;
   logic [DIGITS-1:0] w_new_en;

   // Add-3 correction per digit, then one-bit shift of {scratch, shift}
   always_comb begin
      w_adj = '0;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_scratch[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
         else                             w_adj[4*d +: 4] = r_scratch[4*d +: 4];
      end
      w_carry     = w_adj[BW-1];
      w_scr_shift = {w_adj[BW-2:0], r_shift[WIDTH-1]};
   end

   // Digit i is shown if it or any more significant digit is nonzero
   always_comb begin
      w_new_en = '0;
      for (int i = 0; i < DIGITS; i++) begin
         for (int j = i; j < DIGITS; j++) begin
            if (w_scr_shift[4*j +: 4] != 4'd0) w_new_en[i] = 1'b1;
         end
      end
      w_new_en[0] = 1'b1;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_scratch_nxt  = r_scratch;
      w_ovf_nxt      = r_ovf;
      w_cnt_nxt      = r_cnt;
      w_done_nxt     = 1'b0;
      w_bcd_nxt      = r_bcd;
      w_en_nxt       = r_en;
      w_overflow_nxt = r_overflow;
      case (r_state)
         StIdle: begin
            if (start) begin
               w_shift_nxt   = bin;
               w_scratch_nxt = '0;
               w_ovf_nxt     = 1'b0;
               w_cnt_nxt     = CW'(WIDTH);
               w_state_nxt   = StConv;
            end
         end
         StConv: begin
            w_scratch_nxt = w_scr_shift;
            w_shift_nxt   = r_shift << 1;
            w_ovf_nxt     = r_ovf | w_carry;
            w_cnt_nxt     = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               w_bcd_nxt      = w_scr_shift;
               w_overflow_nxt = r_ovf | w_carry;
               w_en_nxt       = w_new_en;
               w_done_nxt     = 1'b1;
               w_state_nxt    = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state    <= StIdle;
         r_shift    <= '0;
         r_scratch  <= '0;
         r_ovf      <= 1'b0;
         r_cnt      <= '0;
         r_done     <= 1'b0;
         r_bcd      <= '0;
         r_en       <= DIGITS'(1);
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_scratch  <= w_scratch_nxt;
         r_ovf      <= w_ovf_nxt;
         r_cnt      <= w_cnt_nxt;
         r_done     <= w_done_nxt;
         r_bcd      <= w_bcd_nxt;
         r_en       <= w_en_nxt;
         r_overflow <= w_overflow_nxt;
      end
   end

   assign busy     = (r_state == StConv);
   assign done     = r_done;
   assign bcd      = r_bcd;
   assign digit_en = r_en;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_score_bcd_encoder.sv
// Directed bench for score_bcd_encoder: default 16-bit/5-digit instance plus a
// 10-bit/3-digit instance for the overflow case.
module tb_score_bcd_encoder;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start, start_s;
   logic [15:0] bin;
   logic [9:0]  bin_s;
   logic        busy, done, overflow;
   logic [19:0] bcd;
   logic [4:0]  digit_en;
   logic        busy_s, done_s, overflow_s;
   logic [11:0] bcd_s;
   logic [2:0]  digit_en_s;

   int n_total = 0;
   int n_bad   = 0;

   always #10 clk = ~clk;

   score_bcd_encoder u_dut (
      .clk(clk), .resetn(resetn), .start(start), .bin(bin), .busy(busy), .done(done),
      .bcd(bcd), .digit_en(digit_en), .overflow(overflow)
   );

   score_bcd_encoder #(.WIDTH(10), .DIGITS(3)) u_dut_s (
      .clk(clk), .resetn(resetn), .start(start_s), .bin(bin_s), .busy(busy_s), .done(done_s),
      .bcd(bcd_s), .digit_en(digit_en_s), .overflow(overflow_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " bcd"}, 32'(bcd), 32'h0);
      check({tag, " en"}, 32'(digit_en), 32'h01);
      check({tag, " ovf"}, 32'(overflow), 32'd0);
   endtask

   // One conversion on the 16-bit instance: checks latency and result
   task automatic convert(input logic [15:0] v, input logic [19:0] exp_bcd,
                          input logic [4:0] exp_en, input logic exp_ovf);
      int k;
      bin   = v;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("accept busy", 32'(busy), 32'd1);
      k = 0;
      while (!done && k < 40) begin
         tick();
         k++;
      end
      check("latency", 32'(k), 32'd16);
      check("done busy", 32'(busy), 32'd0);
      check("bcd", 32'(bcd), 32'(exp_bcd));
      check("en", 32'(digit_en), 32'(exp_en));
      check("ovf", 32'(overflow), 32'(exp_ovf));
      tick();
      check("done one cycle", 32'(done), 32'd0);
   endtask

   task automatic convert_s(input logic [9:0] v, input logic [11:0] exp_bcd,
                            input logic [2:0] exp_en, input logic exp_ovf);
      int k;
      bin_s   = v;
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      k = 0;
      while (!done_s && k < 30) begin
         tick();
         k++;
      end
      check("s latency", 32'(k), 32'd10);
      check("s bcd", 32'(bcd_s), 32'(exp_bcd));
      check("s en", 32'(digit_en_s), 32'(exp_en));
      check("s ovf", 32'(overflow_s), 32'(exp_ovf));
   endtask

   initial begin
      int ndone, d1, d2, k;
      logic [19:0] v1, v2;

      resetn = 1'b0; start = 1'b0; start_s = 1'b0; bin = '0; bin_s = '0;
      repeat (3) tick();
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) check_reset_outputs("idle");

      convert(16'd0,     20'h00000, 5'b00001, 1'b0);
      convert(16'd65535, 20'h65535, 5'b11111, 1'b0);
      convert(16'd1234,  20'h01234, 5'b01111, 1'b0);

      // Second request mid-conversion must be dropped, display must hold
      bin = 16'd42; start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0; d1 = 0; v1 = '0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (c == 5) begin start = 1'b1; bin = 16'd999; end
         if (c == 6) start = 1'b0;
         if (done) begin ndone++; d1 = c; v1 = bcd; end
         else if (busy) check("hold bcd", 32'(bcd), 32'h01234);
      end
      check("ignore ndone", 32'(ndone), 32'd1);
      check("ignore latency", 32'(d1), 32'd16);
      check("ignore bcd", 32'(v1), 32'h00042);

      // start held high: back-to-back conversions
      bin = 16'd7; start = 1'b1;
      tick();
      bin = 16'd8;
      ndone = 0; d1 = 0; d2 = 0; v1 = '0; v2 = '0;
      for (int c = 1; c <= 36; c++) begin
         tick();
         if (done) begin
            ndone++;
            if (ndone == 1) begin d1 = c; v1 = bcd; end
            if (ndone == 2) begin d2 = c; v2 = bcd; end
         end
      end
      start = 1'b0;
      check("b2b ndone", 32'(ndone), 32'd2);
      check("b2b first", 32'(d1), 32'd16);
      check("b2b spacing", 32'(d2 - d1), 32'd17);
      check("b2b v1", 32'(v1), 32'h00007);
      check("b2b v2", 32'(v2), 32'h00008);
      k = 0;
      while (busy && k < 40) begin tick(); k++; end
      check("b2b drain", 32'(busy), 32'd0);

      convert_s(10'd999,  12'h999, 3'b111, 1'b0);
      convert_s(10'd1000, 12'h000, 3'b001, 1'b1);

      // Reset in the middle of a conversion of 500
      bin = 16'd500; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      check("pre-reset busy", 32'(busy), 32'd1);
      resetn = 1'b0;
      tick();
      check_reset_outputs("mid reset");
      check("mid reset s ovf", 32'(overflow_s), 32'd0);
      check("mid reset s en", 32'(digit_en_s), 32'h1);
      tick();
      resetn = 1'b1;
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (done) ndone++;
      end
      check("no done after reset", 32'(ndone), 32'd0);
      check_reset_outputs("post reset");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
